// File: rtl/multi_leg_deadtime_pkg.sv
// Shared definitions for the multi-leg dead-time generator: leg state encoding,
// gate-pair payload and default parameter values.
package multi_leg_deadtime_pkg;

  localparam int unsigned DEF_NUM_LEGS     = 3;
  localparam int unsigned DEF_CNT_W        = 8;
  localparam int unsigned DEFAULT_DT_COUNT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } leg_state_e;

  typedef struct packed {
    logic q1;
    logic q2;
  } gate_pair_t;

endpackage

// File: rtl/multi_leg_deadtime_if.sv
// Command/status bundle between a controller and the dead-time generator.
interface multi_leg_deadtime_if
  import multi_leg_deadtime_pkg::*;
#(
  parameter int unsigned NUM_LEGS = DEF_NUM_LEGS,
  parameter int unsigned CNT_W    = DEF_CNT_W
);

  logic                EN;
  logic [CNT_W-1:0]    DT_COUNT;
  logic [NUM_LEGS-1:0] Sin;
  logic                FAULT;
  logic                FAULT_CLR;
  logic [NUM_LEGS-1:0] Q1;
  logic [NUM_LEGS-1:0] Q2;
  logic                FAULT_LATCHED;

  modport master (
    output EN, DT_COUNT, Sin, FAULT, FAULT_CLR,
    input  Q1, Q2, FAULT_LATCHED
  );

  modport slave (
    input  EN, DT_COUNT, Sin, FAULT, FAULT_CLR,
    output Q1, Q2, FAULT_LATCHED
  );

endinterface

// File: rtl/multi_leg_deadtime_leg.sv
// Single half-bridge leg: IDLE/DEAD/HI/LO state machine with a per-leg
// dead-time counter and registered gate drives.
module deadtime_leg
  import multi_leg_deadtime_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             halt,
  input  logic             s,
  input  logic [CNT_W-1:0] dt_count,
  output logic             q1,
  output logic             q2
);

  leg_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dt_lat;
  gate_pair_t       gates;

  // Gates are only ever set together with HI/LO, so both can never be high at once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      dt_lat <= '0;
      gates  <= '0;
    end else if (halt) begin
      state <= ST_IDLE;
      gates <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state  <= ST_DEAD;
          cnt    <= '0;
          dt_lat <= dt_count;
          gates  <= '0;
        end
        ST_DEAD: begin
          // Equality against the latched value; counter never passes it, so no wrap.
          if (cnt == dt_lat) begin
            state <= s ? ST_HI : ST_LO;
            gates <= '{q1: s, q2: ~s};
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HI: begin
          if (!s) begin
            state  <= ST_DEAD;
            cnt    <= '0;
            dt_lat <= dt_count;
            gates  <= '0;
          end
        end
        ST_LO: begin
          if (s) begin
            state  <= ST_DEAD;
            cnt    <= '0;
            dt_lat <= dt_count;
            gates  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          gates <= '0;
        end
      endcase
    end
  end

  assign q1 = gates.q1;
  assign q2 = gates.q2;

endmodule

// File: rtl/multi_leg_deadtime.sv
// Multi-leg dead-time generator: NUM_LEGS independent legs sharing enable,
// dead-time setting and a latched fault shutdown.
module multi_leg_deadtime
  import multi_leg_deadtime_pkg::*;
#(
  parameter int unsigned NUM_LEGS = DEF_NUM_LEGS,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input logic                 CLK,
  input logic                 RST,
  multi_leg_deadtime_if.slave bus
);

  logic                fault_latched;
  logic                halt_c;
  logic [NUM_LEGS-1:0] q1_w;
  logic [NUM_LEGS-1:0] q2_w;

  // A fault clear is honoured only when the fault input itself is low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fault_latched <= 1'b0;
    end else if (bus.FAULT) begin
      fault_latched <= 1'b1;
    end else if (bus.FAULT_CLR) begin
      fault_latched <= 1'b0;
    end
  end

  // Live fault, latched fault and disable all force the legs back to IDLE.
  assign halt_c = bus.FAULT | fault_latched | ~bus.EN;

  for (genvar i = 0; i < NUM_LEGS; i++) begin : g_leg
    deadtime_leg #(
      .CNT_W (CNT_W)
    ) u_leg (
      .CLK      (CLK),
      .RST      (RST),
      .halt     (halt_c),
      .s        (bus.Sin[i]),
      .dt_count (bus.DT_COUNT),
      .q1       (q1_w[i]),
      .q2       (q2_w[i])
    );
  end

  assign bus.Q1            = q1_w;
  assign bus.Q2            = q2_w;
  assign bus.FAULT_LATCHED = fault_latched;

endmodule

// File: tb/tb_multi_leg_deadtime.sv
// Scoreboard bench for multi_leg_deadtime: directed per-edge vectors push
// hand-computed gate/fault expectations, a monitor pops and compares them.
module tb_multi_leg_deadtime;
  import multi_leg_deadtime_pkg::*;

  typedef struct {
    logic [2:0] q1;
    logic [2:0] q2;
    logic       fl;
    string      tag;
  } exp_t;

  logic CLK;
  logic RST;
  int   total;
  int   bad;
  exp_t sb[$];

  multi_leg_deadtime_if #(.NUM_LEGS(3), .CNT_W(8)) bus ();

  multi_leg_deadtime #(
    .NUM_LEGS (3),
    .CNT_W    (8)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one edge's inputs and queue the outputs expected right after that edge.
  task automatic cyc(input logic rst, input logic en, input logic [7:0] dt,
                     input logic [2:0] s, input logic f, input logic fc,
                     input logic [2:0] eq1, input logic [2:0] eq2,
                     input logic efl, input string tag);
    exp_t e;
    RST           = rst;
    bus.EN        = en;
    bus.DT_COUNT  = dt;
    bus.Sin       = s;
    bus.FAULT     = f;
    bus.FAULT_CLR = fc;
    e.q1  = eq1;
    e.q2  = eq2;
    e.fl  = efl;
    e.tag = tag;
    sb.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  task automatic rep(input int n, input logic rst, input logic en,
                     input logic [7:0] dt, input logic [2:0] s, input logic f,
                     input logic fc, input logic [2:0] eq1, input logic [2:0] eq2,
                     input logic efl, input string tag);
    for (int i = 0; i < n; i++) cyc(rst, en, dt, s, f, fc, eq1, eq2, efl, tag);
  endtask

  // Monitor: compares every edge's outputs against the oldest queued expectation.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        total++;
        if (bus.Q1 !== e.q1) begin
          bad++;
          $display("FAIL %s Q1: got %b want %b at %0t", e.tag, bus.Q1, e.q1, $time);
        end
        total++;
        if (bus.Q2 !== e.q2) begin
          bad++;
          $display("FAIL %s Q2: got %b want %b at %0t", e.tag, bus.Q2, e.q2, $time);
        end
        total++;
        if (bus.FAULT_LATCHED !== e.fl) begin
          bad++;
          $display("FAIL %s FAULT_LATCHED: got %b want %b at %0t", e.tag,
                   bus.FAULT_LATCHED, e.fl, $time);
        end
        total++;
        if ((bus.Q1 & bus.Q2) !== 3'b000) begin
          bad++;
          $display("FAIL %s overlap: got Q1&Q2=%b want 000 at %0t", e.tag,
                   bus.Q1 & bus.Q2, $time);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    // rst en dt s f fc | q1 q2 fl
    rep(2, 1, 0, 8'd4, 3'b000, 0, 0, 3'b000, 3'b000, 0, "reset");
    // First enable: 5 both-off cycles, then leg0 high, legs1-2 low
    rep(5, 0, 1, 8'(DEFAULT_DT_COUNT), 3'b001, 0, 0, 3'b000, 3'b000, 0, "start_dead");
    rep(3, 0, 1, 8'd4, 3'b001, 0, 0, 3'b001, 3'b110, 0, "start_cond");
    // DT_COUNT=0: exactly one both-off cycle on leg0
    cyc(0, 1, 8'd0, 3'b000, 0, 0, 3'b000, 3'b110, 0, "dt0_dead");
    rep(2, 0, 1, 8'd0, 3'b000, 0, 0, 3'b000, 3'b111, 0, "dt0_lo");
    // DT_COUNT changed mid-DEAD: current interval stays 5
    cyc(0, 1, 8'd4, 3'b001, 0, 0, 3'b000, 3'b110, 0, "dtchg_enter");
    rep(4, 0, 1, 8'd20, 3'b001, 0, 0, 3'b000, 3'b110, 0, "dtchg_dead");
    rep(2, 0, 1, 8'd20, 3'b001, 0, 0, 3'b001, 3'b110, 0, "dtchg_hi");
    // Next transition uses the new value: 21 both-off cycles
    rep(21, 0, 1, 8'd20, 3'b000, 0, 0, 3'b000, 3'b110, 0, "dt20_dead");
    cyc(0, 1, 8'd20, 3'b000, 0, 0, 3'b000, 3'b111, 0, "dt20_lo");
    rep(5, 0, 1, 8'd4, 3'b001, 0, 0, 3'b000, 3'b110, 0, "rehi_dead");
    rep(2, 0, 1, 8'd4, 3'b001, 0, 0, 3'b001, 3'b110, 0, "rehi_cond");
    // Sin glitch 1->0->1: full interval, exit back to HI
    rep(2, 0, 1, 8'd4, 3'b000, 0, 0, 3'b000, 3'b110, 0, "glitch_low");
    rep(3, 0, 1, 8'd4, 3'b001, 0, 0, 3'b000, 3'b110, 0, "glitch_dead");
    rep(2, 0, 1, 8'd4, 3'b001, 0, 0, 3'b001, 3'b110, 0, "glitch_hi");
    // Fault pulse, ignored clear, real clear, resume through full DEAD
    cyc(0, 1, 8'd4, 3'b001, 1, 0, 3'b000, 3'b000, 1, "fault_hit");
    rep(2, 0, 1, 8'd4, 3'b001, 0, 0, 3'b000, 3'b000, 1, "fault_hold");
    cyc(0, 1, 8'd4, 3'b001, 1, 1, 3'b000, 3'b000, 1, "fault_clr_ign");
    cyc(0, 1, 8'd4, 3'b001, 0, 1, 3'b000, 3'b000, 0, "fault_clr");
    rep(5, 0, 1, 8'd4, 3'b001, 0, 0, 3'b000, 3'b000, 0, "fault_dead");
    rep(2, 0, 1, 8'd4, 3'b001, 0, 0, 3'b001, 3'b110, 0, "fault_resume");
    // Fault wins over EN=0 in the same edge
    cyc(0, 0, 8'd4, 3'b001, 1, 0, 3'b000, 3'b000, 1, "fault_en0");
    cyc(0, 1, 8'd4, 3'b001, 0, 1, 3'b000, 3'b000, 0, "fault_en0_clr");
    rep(5, 0, 1, 8'd4, 3'b001, 0, 0, 3'b000, 3'b000, 0, "fault_en0_dead");
    cyc(0, 1, 8'd4, 3'b001, 0, 0, 3'b001, 3'b110, 0, "fault_en0_cond");
    // EN drop and return through full DEAD
    cyc(0, 0, 8'd4, 3'b001, 0, 0, 3'b000, 3'b000, 0, "en_off");
    rep(5, 0, 1, 8'd4, 3'b001, 0, 0, 3'b000, 3'b000, 0, "en_dead");
    rep(2, 0, 1, 8'd4, 3'b001, 0, 0, 3'b001, 3'b110, 0, "en_cond");
    // Reset mid-DEAD
    cyc(0, 1, 8'd4, 3'b000, 0, 0, 3'b000, 3'b110, 0, "rst_pre");
    cyc(1, 1, 8'd4, 3'b000, 0, 0, 3'b000, 3'b000, 0, "rst_middead");
    rep(5, 0, 1, 8'd4, 3'b000, 0, 0, 3'b000, 3'b000, 0, "rst_dead");
    rep(2, 0, 1, 8'd4, 3'b000, 0, 0, 3'b000, 3'b111, 0, "rst_cond");
    // Reset mid-conduction, reset beats a live fault
    cyc(1, 1, 8'd4, 3'b000, 1, 0, 3'b000, 3'b000, 0, "rst_midcond");
    rep(5, 0, 1, 8'd4, 3'b000, 0, 0, 3'b000, 3'b000, 0, "rst2_dead");
    cyc(0, 1, 8'd4, 3'b000, 0, 0, 3'b000, 3'b111, 0, "rst2_cond");
    // Maximum dead time: 256 both-off cycles
    cyc(0, 1, 8'd255, 3'b001, 0, 0, 3'b000, 3'b110, 0, "dtmax_enter");
    rep(255, 0, 1, 8'd0, 3'b001, 0, 0, 3'b000, 3'b110, 0, "dtmax_dead");
    rep(2, 0, 1, 8'd0, 3'b001, 0, 0, 3'b001, 3'b110, 0, "dtmax_hi");
    cyc(1, 0, 8'd0, 3'b000, 0, 0, 3'b000, 3'b000, 0, "final_reset");

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_leg_deadtime.md
MULTI_LEG_DEADTIME -- requirements
Module: multi_leg_deadtime

Interface
REQ-001 Parameter NUM_LEGS, default 3: number of independent half-bridge legs.
REQ-002 Parameter CNT_W, default 8: width of the dead-time count and per-leg counter.
REQ-003 CLK  input  1  system clock, 50 MHz; all logic on rising edge only.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 EN  input  1  1 = legs may conduct; 0 = all switches off.
REQ-006 DT_COUNT  input  CNT_W  dead-time setting; both-off interval = (DT_COUNT+1) CLK cycles.
REQ-007 Sin  input  NUM_LEGS  per-leg command; 1 = leg high, 0 = leg low.
REQ-008 FAULT  input  1  external fault, level-sensitive, synchronous sample.
REQ-009 FAULT_CLR  input  1  single-cycle request to clear latched fault.
REQ-010 Q1  output  NUM_LEGS  top-switch gate per leg, registered.
REQ-011 Q2  output  NUM_LEGS  bottom-switch gate per leg, registered.
REQ-012 FAULT_LATCHED  output  1  1 while shutdown due to fault, registered.

Function
REQ-013 Each leg SHALL run an independent FSM with states IDLE (Q1=0,Q2=0), DEAD (Q1=0,Q2=0), HI (Q1=1,Q2=0), LO (Q1=0,Q2=1).
REQ-014 IDLE -> DEAD when EN=1 and not halted; a leg SHALL never leave IDLE directly for HI or LO.
REQ-015 HI -> DEAD when sampled Sin[i]=0; LO -> DEAD when sampled Sin[i]=1; otherwise hold.
REQ-016 On DEAD entry, counter SHALL clear to 0 and DT_COUNT SHALL be latched per leg; later DT_COUNT changes SHALL not affect the current interval.
REQ-017 In DEAD, counter increments each cycle; when counter equals latched value, next state SHALL be HI if Sin[i]=1, else LO, sampled at that edge.
REQ-018 Sin reverting during DEAD SHALL NOT shorten or restart the interval; exit state follows Sin at expiry.
REQ-019 Latency: Sin edge sampled at edge k -> both gates 0 from edge k; opposite gate asserts at edge k+DT_COUNT+1; DT_COUNT=0 gives 1-cycle dead time.
REQ-020 Q1[i] and Q2[i] SHALL never be 1 in the same cycle, under any input sequence including reset and fault.
REQ-021 EN=0 sampled -> all legs IDLE and all gates 0 at that edge; EN returning to 1 SHALL pass through full DEAD first.
REQ-022 FAULT=1 sampled -> FAULT_LATCHED=1 and all legs IDLE at that edge; held until FAULT_CLR=1 sampled with FAULT=0.
REQ-023 FAULT_CLR with FAULT=1 in the same cycle SHALL be ignored (fault stays latched).
REQ-024 Priority per edge: RST > FAULT/FAULT_LATCHED > EN=0 > normal FSM.
REQ-025 Counter SHALL not wrap: comparison is equality against latched value, which is <= 2^CNT_W-1.

Reset
REQ-026 RST=1 sampled SHALL set every leg to IDLE, counters and latched dead-time to 0, Q1=0, Q2=0, FAULT_LATCHED=0.
REQ-027 RST asserted mid-DEAD or mid-conduction SHALL force gates to 0 at that edge; first conduction after release requires a full DEAD interval.

Structure
REQ-028 State encodings (IDLE=0, DEAD=1, HI=2, LO=3) and default DT_COUNT value (4) SHALL reside in a shared pwm_defs package/include.
REQ-029 One sub-module, deadtime_leg, SHALL implement a single leg FSM+counter; top instantiates NUM_LEGS copies via generate and holds fault/enable logic.

Verification
REQ-030 Reset then EN=1, Sin=3'b001, DT_COUNT=4 -> leg0 Q1=1 after 5 cycles both-off; legs1-2 Q2=1 after 5 cycles.
REQ-031 Leg0 in HI, Sin[0] 1->0, DT_COUNT=0 -> exactly 1 cycle Q1=Q2=0, then Q2[0]=1.
REQ-032 DT_COUNT 4 changed to 20 mid-DEAD -> current interval stays 5 cycles; next transition uses 21.
REQ-033 Sin[0] glitch 1->0->1 (2 cycles) with DT_COUNT=4 -> 5-cycle dead time then back to HI.
REQ-034 FAULT pulse 1 cycle while conducting -> all gates 0 next edge, FAULT_LATCHED=1; FAULT_CLR with FAULT=1 ignored; FAULT_CLR with FAULT=0 -> resume via full DEAD.
REQ-035 Random Sin/EN/RST/FAULT, 10^6 cycles, NUM_LEGS=6, CNT_W=4 -> assertion Q1&Q2==0 never fires; every conduction preceded by >=DT_COUNT+1 both-off cycles.
